flit_injector: RTL and testbench

Credit-based flit source for one router input port: the transmitter that drives a Router's `flit_in` / `flit_in_valid` / `flit_ack` lanes and consumes the credits the router returns. It buffers timestamped flits from a traffic source, releases each flit only once `sim_time` has reached its timestamp and the target VC holds a credit, and tracks per-VC downstream buffer occupancy. It sits between a traffic generator and the router in the DART simulation fabric.

---
 rtl/flit_injector_pkg.sv | 21 ++
 rtl/flit_injector_queue.sv | 49 ++++
 rtl/flit_injector.sv | 169 ++++++++++++++++
 tb/tb_flit_injector.sv | 361 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/flit_injector_pkg.sv
// Shared widths and helpers for the flit injector.
package flit_injector_pkg;

    localparam int unsigned FLIT_WIDTH   = 16;
    localparam int unsigned TS_WIDTH     = 16;
    localparam int unsigned CREDIT_WIDTH = 4;

    // Number of bits needed to hold value (1 -> 1, 3 -> 2, 4 -> 3).
    function automatic int unsigned clogb2(input int unsigned value);
        int unsigned v;
        int unsigned r;
        v = value;
        r = 0;
        while (v > 0) begin
            r = r + 1;
            v = v >> 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/flit_injector_queue.sv
// Synchronous FIFO with a combinational head; power-of-two depth.
module injector_queue #(
    parameter int unsigned WIDTH  = 8,
    parameter int unsigned DEPTH  = 4,
    parameter int unsigned ADDR_W = 2
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] head,
    output logic             full,
    output logic             empty
);

    localparam logic [ADDR_W:0] PTR_ONE = {{ADDR_W{1'b0}}, 1'b1};

    logic [WIDTH-1:0] mem [DEPTH];
    logic [ADDR_W:0]  wr_ptr;
    logic [ADDR_W:0]  rd_ptr;

    // Extra pointer bit tells full from empty when the indices match.
    assign head  = mem[rd_ptr[ADDR_W-1:0]];
    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[ADDR_W] != rd_ptr[ADDR_W]) &&
                   (wr_ptr[ADDR_W-1:0] == rd_ptr[ADDR_W-1:0]);

    always_ff @(posedge clock) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push && !full) begin
                wr_ptr <= wr_ptr + PTR_ONE;
            end
            if (pop && !empty) begin
                rd_ptr <= rd_ptr + PTR_ONE;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (push && !full) begin
            mem[wr_ptr[ADDR_W-1:0]] <= din;
        end
    end

endmodule

// File: rtl/flit_injector.sv
// Credit-based flit source for one router input port: releases queued flits in
// order once sim_time reaches their timestamp and their VC holds a credit.
module flit_injector
    import flit_injector_pkg::*;
#(
    parameter int unsigned NVCS      = 2,
    parameter int unsigned BUF_DEPTH = 4,
    parameter int unsigned QDEPTH    = 4,
    localparam int unsigned LOG_NVCS = clogb2(NVCS - 1)
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    enable,
    input  logic [TS_WIDTH-1:0]     sim_time,
    input  logic [FLIT_WIDTH-1:0]   src_flit,
    input  logic [LOG_NVCS-1:0]     src_vc,
    input  logic [TS_WIDTH-1:0]     src_ts,
    input  logic                    src_valid,
    output logic                    src_ready,
    output logic [FLIT_WIDTH-1:0]   flit_out,
    output logic [NVCS-1:0]         flit_out_valid,
    input  logic                    flit_ack,
    input  logic [CREDIT_WIDTH-1:0] credit_in,
    input  logic                    credit_in_valid,
    output logic                    credit_ack,
    output logic                    is_quiescent,
    output logic                    error
);

    localparam int unsigned     LOG_Q       = clogb2(QDEPTH - 1);
    localparam int unsigned     CW          = clogb2(BUF_DEPTH) + 1;
    localparam logic [CW-1:0]   CREDIT_FULL = CW'(BUF_DEPTH);
    localparam logic [CW-1:0]   CREDIT_ONE  = CW'(1);
    localparam logic [NVCS-1:0] LANE0       = NVCS'(1);
    localparam logic [0:0]      S_IDLE      = 1'b0;
    localparam logic [0:0]      S_SEND      = 1'b1;

    typedef struct packed {
        logic [TS_WIDTH-1:0]   ts;
        logic [LOG_NVCS-1:0]   vc;
        logic [FLIT_WIDTH-1:0] flit;
    } entry_t;

    logic [0:0]          state;
    logic [0:0]          state_nxt;
    logic                launch;
    logic                drop;
    logic                push;
    logic                q_full;
    logic                q_empty;
    entry_t              push_entry;
    entry_t              head;
    logic                head_eligible;
    logic [CW-1:0]       credits [NVCS];
    logic [NVCS-1:0]     credit_inc;
    logic [NVCS-1:0]     credit_dec;
    logic [LOG_NVCS-1:0] credit_vc;
    logic                credits_home;
    logic                unused_credit_bits;

    assign src_ready          = enable & ~q_full & reset;
    assign credit_ack         = enable & credit_in_valid & reset;
    assign push               = src_valid & src_ready;
    assign push_entry         = '{ts: src_ts, vc: src_vc, flit: src_flit};
    assign credit_vc          = credit_in[LOG_NVCS-1:0];
    assign unused_credit_bits = ^credit_in[CREDIT_WIDTH-1:LOG_NVCS];

    injector_queue #(
        .WIDTH  ($bits(entry_t)),
        .DEPTH  (QDEPTH),
        .ADDR_W (LOG_Q)
    ) u_queue (
        .clock (clock),
        .reset (reset),
        .push  (push),
        .pop   (launch),
        .din   (push_entry),
        .head  (head),
        .full  (q_full),
        .empty (q_empty)
    );

    // Uses registered credits, so a credit returned this cycle counts next cycle.
    assign head_eligible = !q_empty && (head.ts <= sim_time) &&
                           (credits[head.vc] != '0);

    always_ff @(posedge clock) begin
        if (!reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        launch    = 1'b0;
        drop      = 1'b0;
        if (enable) begin
            case (state)
                S_IDLE: begin
                    if (head_eligible) begin
                        launch    = 1'b1;
                        state_nxt = S_SEND;
                    end
                end
                S_SEND: begin
                    if (flit_ack) begin
                        if (head_eligible) begin
                            launch = 1'b1;
                        end else begin
                            drop      = 1'b1;
                            state_nxt = S_IDLE;
                        end
                    end
                end
                default: state_nxt = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            flit_out       <= '0;
            flit_out_valid <= '0;
        end else if (launch) begin
            flit_out       <= head.flit;
            flit_out_valid <= LANE0 << head.vc;
        end else if (drop) begin
            flit_out_valid <= '0;
        end
    end

    always_comb begin
        credit_inc   = '0;
        credit_dec   = '0;
        credits_home = 1'b1;
        for (int i = 0; i < int'(NVCS); i++) begin
            credit_inc[i] = enable & credit_in_valid & (credit_vc == LOG_NVCS'(i));
            credit_dec[i] = launch & (head.vc == LOG_NVCS'(i));
            credits_home  = credits_home & (credits[i] == CREDIT_FULL);
        end
    end

    // Return and launch on the same VC cancel; a return onto a full counter is an overflow.
    always_ff @(posedge clock) begin
        if (!reset) begin
            for (int i = 0; i < int'(NVCS); i++) begin
                credits[i] <= CREDIT_FULL;
            end
            error <= 1'b0;
        end else begin
            for (int i = 0; i < int'(NVCS); i++) begin
                if (credit_inc[i] && !credit_dec[i]) begin
                    if (credits[i] == CREDIT_FULL) begin
                        error <= 1'b1;
                    end else begin
                        credits[i] <= credits[i] + CREDIT_ONE;
                    end
                end else if (credit_dec[i] && !credit_inc[i]) begin
                    credits[i] <= credits[i] - CREDIT_ONE;
                end
            end
        end
    end

    assign is_quiescent = (state == S_IDLE) & q_empty & credits_home;

endmodule

// File: tb/tb_flit_injector.sv
// Randomized and directed bench for flit_injector against a queue-level model.
module tb_flit_injector;
    import flit_injector_pkg::*;

    localparam int NVCS      = 2;
    localparam int BUF_DEPTH = 4;
    localparam int QDEPTH    = 4;

    logic                    clock;
    logic                    rst_n;
    logic                    enable;
    logic [TS_WIDTH-1:0]     sim_time;
    logic [FLIT_WIDTH-1:0]   src_flit;
    logic [0:0]              src_vc;
    logic [TS_WIDTH-1:0]     src_ts;
    logic                    src_valid;
    logic                    src_ready;
    logic [FLIT_WIDTH-1:0]   flit_out;
    logic [NVCS-1:0]         flit_out_valid;
    logic                    flit_ack;
    logic [CREDIT_WIDTH-1:0] credit_in;
    logic                    credit_in_valid;
    logic                    credit_ack;
    logic                    is_quiescent;
    logic                    error;

    flit_injector #(
        .NVCS      (NVCS),
        .BUF_DEPTH (BUF_DEPTH),
        .QDEPTH    (QDEPTH)
    ) dut (
        .clock           (clock),
        .reset           (rst_n),
        .enable          (enable),
        .sim_time        (sim_time),
        .src_flit        (src_flit),
        .src_vc          (src_vc),
        .src_ts          (src_ts),
        .src_valid       (src_valid),
        .src_ready       (src_ready),
        .flit_out        (flit_out),
        .flit_out_valid  (flit_out_valid),
        .flit_ack        (flit_ack),
        .credit_in       (credit_in),
        .credit_in_valid (credit_in_valid),
        .credit_ack      (credit_ack),
        .is_quiescent    (is_quiescent),
        .error           (error)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    // Reference model: a queue of pending flits, one presented flit, credit counts.
    typedef struct {
        int                    ts;
        int                    vc;
        logic [FLIT_WIDTH-1:0] flit;
    } ent_t;

    ent_t                  mq[$];
    int                    m_cred [NVCS];
    bit                    m_hold;
    int                    m_vc;
    logic [FLIT_WIDTH-1:0] m_flit;
    bit                    m_err;
    bit                    model_valid;

    int n_checks;
    int n_errors;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic exp_src_ready();
        return rst_n && enable && (mq.size() < QDEPTH);
    endfunction

    function automatic logic [NVCS-1:0] exp_valid();
        logic [NVCS-1:0] v;
        v = '0;
        if (m_hold) v[m_vc] = 1'b1;
        return v;
    endfunction

    function automatic logic exp_quiescent();
        logic q;
        q = !m_hold && (mq.size() == 0);
        for (int v = 0; v < NVCS; v++) q = q && (m_cred[v] == BUF_DEPTH);
        return q;
    endfunction

    // Advance the model by one clock edge given the inputs currently applied.
    task automatic model_step();
        int dec [NVCS];
        int nc;
        bit room;
        if (!rst_n) begin
            mq.delete();
            m_hold = 0;
            m_vc = 0;
            m_flit = '0;
            m_err = 0;
            for (int v = 0; v < NVCS; v++) m_cred[v] = BUF_DEPTH;
            model_valid = 1;
            return;
        end
        if (!enable) return;
        for (int v = 0; v < NVCS; v++) dec[v] = 0;
        room = mq.size() < QDEPTH;
        if (m_hold && flit_ack) m_hold = 0;
        if (!m_hold && mq.size() != 0 && mq[0].ts <= int'(sim_time) && m_cred[mq[0].vc] > 0) begin
            m_vc = mq[0].vc;
            m_flit = mq[0].flit;
            void'(mq.pop_front());
            m_hold = 1;
            dec[m_vc] = 1;
        end
        if (src_valid && room)
            mq.push_back('{ts: int'(src_ts), vc: int'(src_vc), flit: src_flit});
        for (int v = 0; v < NVCS; v++) begin
            nc = m_cred[v] - dec[v] + ((credit_in_valid && int'(credit_in[0]) == v) ? 1 : 0);
            if (nc > BUF_DEPTH) begin
                nc = BUF_DEPTH;
                m_err = 1;
            end
            m_cred[v] = nc;
        end
    endtask

    // Called just after a falling edge with inputs applied; returns at the next falling edge.
    task automatic tick();
        #1;
        check_eq("src_ready", src_ready, exp_src_ready());
        check_eq("credit_ack", credit_ack, rst_n && enable && credit_in_valid);
        model_step();
        @(posedge clock);
        #1;
        if (model_valid) begin
            check_eq("flit_out_valid", flit_out_valid, exp_valid());
            check_eq("flit_out", flit_out, m_flit);
            check_eq("error", error, m_err);
            check_eq("is_quiescent", is_quiescent, exp_quiescent());
        end
        @(negedge clock);
    endtask

    task automatic push(input logic [FLIT_WIDTH-1:0] f, input int vc, input int ts);
        bit took;
        took = 0;
        src_flit = f;
        src_vc = 1'(vc);
        src_ts = TS_WIDTH'(ts);
        src_valid = 1'b1;
        for (int k = 0; k < 20 && !took; k++) begin
            took = exp_src_ready();
            tick();
        end
        src_valid = 1'b0;
        check_eq("push_accept", took, 1'b1);
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) tick();
    endtask

    task automatic return_all();
        credit_in_valid = 1'b1;
        for (int v = 0; v < NVCS; v++) begin
            for (int k = 0; k < BUF_DEPTH + 2 && m_cred[v] < BUF_DEPTH; k++) begin
                credit_in = CREDIT_WIDTH'(v);
                tick();
            end
        end
        credit_in_valid = 1'b0;
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        model_valid = 0;
        m_hold = 0;
        m_vc = 0;
        m_flit = '0;
        m_err = 0;
        for (int v = 0; v < NVCS; v++) m_cred[v] = BUF_DEPTH;
        rst_n = 1'b0;
        enable = 1'b1;
        sim_time = '0;
        src_flit = '0;
        src_vc = '0;
        src_ts = '0;
        src_valid = 1'b0;
        flit_ack = 1'b0;
        credit_in = '0;
        credit_in_valid = 1'b1;
        @(negedge clock);

        // Reset with a credit offered: must be refused and state must come up clean.
        idle(2);
        check_eq("reset_quiescent", is_quiescent, 1'b1);
        check_eq("reset_valid", flit_out_valid, 2'b00);
        credit_in_valid = 1'b0;
        rst_n = 1'b1;

        // Basic timestamped launch on vc1.
        push(16'h00A5, 1, 3);
        idle(2);
        check_eq("basic_wait", flit_out_valid, 2'b00);
        sim_time = 16'd3;
        tick();
        check_eq("basic_valid", flit_out_valid, 2'b10);
        check_eq("basic_flit", flit_out, 16'h00A5);
        flit_ack = 1'b1;
        tick();
        flit_ack = 1'b0;
        check_eq("basic_drop", flit_out_valid, 2'b00);
        check_eq("basic_owed", is_quiescent, 1'b0);
        credit_in = 4'h1;
        credit_in_valid = 1'b1;
        tick();
        credit_in_valid = 1'b0;
        check_eq("basic_home", is_quiescent, 1'b1);

        // Credit exhaustion on vc0.
        flit_ack = 1'b1;
        for (int i = 0; i < 5; i++) push(FLIT_WIDTH'(16'h0100 + i), 0, 0);
        idle(2);
        check_eq("exhaust_stall", flit_out_valid, 2'b00);
        credit_in = 4'h0;
        credit_in_valid = 1'b1;
        tick();
        credit_in_valid = 1'b0;
        check_eq("exhaust_credit_only", flit_out_valid, 2'b00);
        tick();
        check_eq("exhaust_resume", flit_out_valid, 2'b01);
        check_eq("exhaust_flit", flit_out, 16'h0104);
        tick();
        flit_ack = 1'b0;
        return_all();

        // Head-of-line blocking across VCs.
        sim_time = 16'd5;
        push(16'h0011, 0, 10);
        push(16'h0022, 1, 0);
        idle(3);
        check_eq("hol_blocked", flit_out_valid, 2'b00);
        sim_time = 16'd10;
        tick();
        check_eq("hol_first", flit_out_valid, 2'b01);
        flit_ack = 1'b1;
        tick();
        check_eq("hol_second", flit_out_valid, 2'b10);
        check_eq("hol_second_flit", flit_out, 16'h0022);
        tick();
        check_eq("hol_done", flit_out_valid, 2'b00);
        flit_ack = 1'b0;
        return_all();

        // Credit return and launch on vc0 in the same cycle.
        push(16'h0033, 0, 0);
        push(16'h0044, 0, 0);
        flit_ack = 1'b1;
        credit_in = 4'h0;
        credit_in_valid = 1'b1;
        tick();
        credit_in_valid = 1'b0;
        check_eq("simul_flit", flit_out, 16'h0044);
        tick();
        flit_ack = 1'b0;
        return_all();
        check_eq("simul_home", is_quiescent, 1'b1);

        // Overflow on vc1, cleared only by reset.
        credit_in = 4'h1;
        credit_in_valid = 1'b1;
        tick();
        credit_in_valid = 1'b0;
        check_eq("ovf_error", error, 1'b1);
        check_eq("ovf_saturated", is_quiescent, 1'b1);
        idle(2);
        check_eq("ovf_sticky", error, 1'b1);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        check_eq("rst_error", error, 1'b0);
        check_eq("rst_quiescent", is_quiescent, 1'b1);

        // Enable freeze while a flit is presented.
        push(16'h0055, 1, 0);
        tick();
        check_eq("freeze_pre", flit_out_valid, 2'b10);
        enable = 1'b0;
        flit_ack = 1'b1;
        src_flit = 16'h0066;
        src_valid = 1'b1;
        idle(2);
        check_eq("freeze_valid", flit_out_valid, 2'b10);
        check_eq("freeze_flit", flit_out, 16'h0055);
        src_valid = 1'b0;
        enable = 1'b1;
        tick();
        check_eq("freeze_release", flit_out_valid, 2'b00);
        flit_ack = 1'b0;
        return_all();

        // Randomized traffic.
        for (int c = 0; c < 2500; c++) begin
            int v;
            rst_n = ($urandom_range(0, 599) != 0);
            enable = ($urandom_range(0, 9) != 0);
            if ($urandom_range(0, 1) != 0) sim_time = sim_time + 16'd1;
            src_valid = ($urandom_range(0, 1) != 0);
            src_vc = 1'($urandom_range(0, 1));
            src_flit = FLIT_WIDTH'($urandom);
            if (sim_time > 16'd2)
                src_ts = TS_WIDTH'(sim_time - 16'd2 + 16'($urandom_range(0, 4)));
            else
                src_ts = TS_WIDTH'($urandom_range(0, 4));
            flit_ack = ($urandom_range(0, 9) < 7);
            v = int'($urandom_range(0, 1));
            credit_in = {3'($urandom), 1'(v)};
            credit_in_valid = (m_cred[v] < BUF_DEPTH) && ($urandom_range(0, 9) < 4);
            tick();
        end

        // Drain: everything delivered and every credit returned.
        rst_n = 1'b1;
        enable = 1'b1;
        src_valid = 1'b0;
        flit_ack = 1'b1;
        sim_time = sim_time + 16'd20;
        for (int k = 0; k < 100; k++) begin
            int v;
            v = k % NVCS;
            credit_in = CREDIT_WIDTH'(v);
            credit_in_valid = (m_cred[v] < BUF_DEPTH);
            tick();
        end
        credit_in_valid = 1'b0;
        tick();
        check_eq("drain_quiescent", is_quiescent, 1'b1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
